// File: rtl/page_alloc_ctrl_pkg.sv
// Shared definitions for the page allocator: FSM state encoding and
// heap-index helpers for the binary "subtree full" tree (root at index 1,
// leaves at PAGES..2*PAGES-1).
package qpl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_FCHK   = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  // Heap index of the first leaf.
  function automatic int unsigned heap_leaf_base(input int unsigned pages);
    return pages;
  endfunction

  // Heap index of the parent node.
  function automatic int unsigned heap_parent(input int unsigned idx);
    return idx >> 1;
  endfunction

  // Heap index of the left child.
  function automatic int unsigned heap_left(input int unsigned idx);
    return idx << 1;
  endfunction

  // Heap index of the right child.
  function automatic int unsigned heap_right(input int unsigned idx);
    return (idx << 1) | 32'd1;
  endfunction

endpackage

// File: rtl/page_alloc_ctrl_if.sv
// Request/response bundle between the page-request front end (master) and
// the page allocator controller (slave).
interface page_alloc_ctrl_if #(
  parameter int PAGES = 16
);
  localparam int DEPTH = $clog2(PAGES);

  logic             i_alloc_req;
  logic             o_alloc_gnt;
  logic             o_alloc_nack;
  logic [DEPTH-1:0] o_alloc_page;
  logic             i_free_vld;
  logic [DEPTH-1:0] i_free_page;
  logic             o_free_ack;
  logic             o_err;
  logic             o_busy;
  logic             o_full;
  logic [DEPTH:0]   o_free_cnt;

  modport master (
    output i_alloc_req, i_free_vld, i_free_page,
    input  o_alloc_gnt, o_alloc_nack, o_alloc_page, o_free_ack, o_err,
           o_busy, o_full, o_free_cnt
  );

  modport slave (
    input  i_alloc_req, i_free_vld, i_free_page,
    output o_alloc_gnt, o_alloc_nack, o_alloc_page, o_free_ack, o_err,
           o_busy, o_full, o_free_cnt
  );

endinterface

// File: rtl/page_alloc_ctrl_chk.sv
// Invariant checker for the page allocator: the walk never sees two full
// children, the free count stays in range, and at rest the root full bit
// agrees with the free count.
module page_alloc_ctrl_chk #(
  parameter int PAGES = 16
) (
  input logic                     i_clk,
  input logic                     i_rstn,
  input logic                     i_walk,
  input logic                     i_stuck,
  input logic                     i_idle,
  input logic                     i_full_root,
  input logic [$clog2(PAGES):0]   i_free_cnt
);
  localparam int DEPTH = $clog2(PAGES);

  a_no_stuck: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_walk |-> !i_stuck);

  a_cnt_range: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_free_cnt <= (DEPTH+1)'(PAGES));

  a_full_vs_cnt: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_idle |-> (i_full_root == (i_free_cnt == {(DEPTH+1){1'b0}})));

endmodule

// File: rtl/page_alloc_ctrl_walk_step.sv
// One level of the allocation walk: picks the child to descend into.
// The policy bit selects the preferred side; a full preferred child forces
// the other side so the walk never enters a full subtree.
module pa_walk_step (
  input  logic i_left_full,
  input  logic i_right_full,
  input  logic i_inv,
  output logic o_go_right,
  output logic o_stuck
);

  // Steering: inv=0 prefers left, inv=1 prefers right.
  always_comb begin
    if (i_inv) begin
      o_go_right = ~i_right_full;
    end else begin
      o_go_right = i_left_full;
    end
    o_stuck = i_left_full & i_right_full;
  end

endmodule

// File: rtl/page_alloc_ctrl.sv
// Page allocator controller: sole writer of the heap-indexed "subtree full"
// tree. Allocations walk root-to-leaf one level per cycle, frees check and
// clear a leaf, and both repair ancestors leaf-to-root afterwards.
// Optional macro QPL_ALLOC_ROTATE_EN: alternate lowest-free-first and
// highest-free-first after every grant (default: always lowest first).
module page_alloc_ctrl
  import qpl_pkg::*;
#(
  parameter int PAGES = 16
) (
  input logic              i_clk,
  input logic              i_rstn,
  page_alloc_ctrl_if.slave bus
);
  localparam int DEPTH = $clog2(PAGES);
  localparam int IDX_W = DEPTH + 1;
  localparam int LVL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;
  logic [2*PAGES-1:1]   full_q, full_d;
  logic [DEPTH:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0]     page_q, page_d;
  logic                 gnt_q, gnt_d;
  logic                 nack_q, nack_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 inv_s;

  logic                 accept_free_s;
  logic                 accept_alloc_s;
  logic                 walk_last_s;
  logic [IDX_W-1:0]     leaf_s;
  logic [IDX_W-1:0]     lc_s, rc_s, child_s;
  logic [IDX_W-1:0]     parent_s, plc_s, prc_s;
  logic                 go_right_s;
  logic                 stuck_s;

`ifdef QPL_ALLOC_ROTATE_EN
  logic inv_q, inv_d;
  assign inv_s = inv_q;
`else
  assign inv_s = 1'b0;
`endif

  assign leaf_s   = IDX_W'(heap_leaf_base(32'(PAGES)) + 32'(bus.i_free_page));
  assign lc_s     = IDX_W'(heap_left(32'(idx_q)));
  assign rc_s     = IDX_W'(heap_right(32'(idx_q)));
  assign child_s  = go_right_s ? rc_s : lc_s;
  assign parent_s = IDX_W'(heap_parent(32'(idx_q)));
  assign plc_s    = IDX_W'(heap_left(32'(parent_s)));
  assign prc_s    = IDX_W'(heap_right(32'(parent_s)));

  assign walk_last_s    = (lvl_q == LVL_W'(DEPTH - 1));
  assign accept_free_s  = (state_q == ST_IDLE) && bus.i_free_vld;
  // The cycle showing a nack is skipped so a requester still holding the
  // request for that cycle is not nacked twice.
  assign accept_alloc_s = (state_q == ST_IDLE) && !bus.i_free_vld &&
                          bus.i_alloc_req && !nack_q;

  pa_walk_step u_step (
    .i_left_full  (full_q[lc_s]),
    .i_right_full (full_q[rc_s]),
    .i_inv        (inv_s),
    .o_go_right   (go_right_s),
    .o_stuck      (stuck_s)
  );

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      lvl_q   <= {LVL_W{1'b0}};
      full_q  <= {(2*PAGES-1){1'b0}};
      cnt_q   <= (DEPTH+1)'(PAGES);
      page_q  <= {DEPTH{1'b0}};
      gnt_q   <= 1'b0;
      nack_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef QPL_ALLOC_ROTATE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      gnt_q   <= gnt_d;
      nack_q  <= nack_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef QPL_ALLOC_ROTATE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Next-state logic: free wins over alloc in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_free_s) begin
          state_d = ST_FCHK;
        end else if (accept_alloc_s && !full_q[1]) begin
          state_d = ST_WALK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (walk_last_s) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_COMMIT: state_d = ST_UPDATE;
      ST_FCHK: begin
        if (full_q[idx_q]) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (parent_s == IDX_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output pulses; pulses are registered so they appear in
  // the cycle after the decision.
  always_comb begin
    idx_d  = idx_q;
    lvl_d  = lvl_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    page_d = page_q;
    gnt_d  = 1'b0;
    nack_d = 1'b0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
`ifdef QPL_ALLOC_ROTATE_EN
    inv_d  = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_free_s) begin
          idx_d = leaf_s;
          ack_d = full_q[leaf_s];
          err_d = ~full_q[leaf_s];
        end else if (accept_alloc_s) begin
          if (full_q[1]) begin
            nack_d = 1'b1;
          end else begin
            idx_d = IDX_W'(1);
            lvl_d = {LVL_W{1'b0}};
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_WALK: begin
        idx_d = child_s;
        if (walk_last_s) begin
          gnt_d  = 1'b1;
          page_d = DEPTH'(32'(child_s) - heap_leaf_base(32'(PAGES)));
        end else begin
          lvl_d = lvl_q + LVL_W'(1);
        end
      end
      ST_COMMIT: begin
        full_d[idx_q] = 1'b1;
        if (cnt_q != {(DEPTH+1){1'b0}}) begin
          cnt_d = cnt_q - (DEPTH+1)'(1);
        end else begin
          cnt_d = cnt_q;
        end
`ifdef QPL_ALLOC_ROTATE_EN
        inv_d = ~inv_q;
`endif
      end
      ST_FCHK: begin
        if (full_q[idx_q] && (cnt_q != (DEPTH+1)'(PAGES))) begin
          full_d[idx_q] = 1'b0;
          cnt_d         = cnt_q + (DEPTH+1)'(1);
        end else begin
          full_d[idx_q] = 1'b0;
        end
      end
      ST_UPDATE: begin
        idx_d            = parent_s;
        full_d[parent_s] = full_q[plc_s] & full_q[prc_s];
      end
      default: begin
        idx_d = {IDX_W{1'b0}};
      end
    endcase
  end

  assign bus.o_alloc_gnt  = gnt_q;
  assign bus.o_alloc_nack = nack_q;
  assign bus.o_alloc_page = page_q;
  assign bus.o_free_ack   = ack_q;
  assign bus.o_err        = err_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_full       = full_q[1];
  assign bus.o_free_cnt   = cnt_q;

  page_alloc_ctrl_chk #(.PAGES(PAGES)) u_chk (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_walk      (state_q == ST_WALK),
    .i_stuck     (stuck_s),
    .i_idle      (state_q == ST_IDLE),
    .i_full_root (full_q[1]),
    .i_free_cnt  (cnt_q)
  );

endmodule

// File: tb/tb_page_alloc_ctrl.sv
// Directed bench for page_alloc_ctrl with PAGES=8. Inputs change and outputs
// are sampled on the falling edge; "cycle +n" is the n-th falling edge after
// the request was driven.
module tb_page_alloc_ctrl;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  page_alloc_ctrl_if #(.PAGES(8)) bus ();

  page_alloc_ctrl #(.PAGES(8)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.i_alloc_req = 1'b0;
    bus.i_free_vld  = 1'b0;
    bus.i_free_page = 3'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", bus.o_busy, n);
    end
  endtask

  // Drives one alloc request until gnt or nack (bounded) and reports latency.
  task automatic run_alloc(output bit gnt, output bit nack,
                           output logic [2:0] pg, output int lat);
    gnt = 1'b0; nack = 1'b0; pg = 3'd0; lat = 0;
    bus.i_alloc_req = 1'b1;
    while (!gnt && !nack && lat < 40) begin
      @(negedge clk);
      lat++;
      gnt  = bus.o_alloc_gnt;
      nack = bus.o_alloc_nack;
      pg   = bus.o_alloc_page;
    end
    bus.i_alloc_req = 1'b0;
  endtask

  // Drives one free request until ack or err (bounded).
  task automatic run_free(input logic [2:0] page, output bit ack,
                          output bit err, output int lat);
    ack = 1'b0; err = 1'b0; lat = 0;
    bus.i_free_vld  = 1'b1;
    bus.i_free_page = page;
    while (!ack && !err && lat < 40) begin
      @(negedge clk);
      lat++;
      ack = bus.o_free_ack;
      err = bus.o_err;
    end
    bus.i_free_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.o_alloc_gnt, bus.o_alloc_nack, bus.o_free_ack, bus.o_err,
         bus.o_busy, bus.o_full} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.o_alloc_gnt, bus.o_alloc_nack, bus.o_free_ack, bus.o_err,
                bus.o_busy, bus.o_full});
    end
    checks++;
    if (bus.o_free_cnt !== 4'd8 || bus.o_alloc_page !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt_page: got cnt %0d page %0d expected 8 0",
               bus.o_free_cnt, bus.o_alloc_page);
    end
  endtask

  task automatic test_single_alloc();
    bit g, nk; logic [2:0] pg; int lat;
    run_alloc(g, nk, pg, lat);
    checks++;
    if (!g || lat !== 4 || pg !== 3'd0) begin
      errors++;
      $display("FAIL single_gnt: got gnt %0b lat %0d page %0d expected 1 4 0", g, lat, pg);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_t7: got %0b expected 1", bus.o_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_free_cnt !== 4'd7) begin
      errors++;
      $display("FAIL single_t8: got busy %0b cnt %0d expected 0 7", bus.o_busy, bus.o_free_cnt);
    end
  endtask

  task automatic test_fill_and_nack();
    bit g, nk; logic [2:0] pg; int lat;
    for (int i = 1; i < 8; i++) begin
      wait_idle();
      run_alloc(g, nk, pg, lat);
      checks++;
      if (!g || pg !== 3'(i)) begin
        errors++;
        $display("FAIL fill_page: got gnt %0b page %0d expected 1 %0d", g, pg, i);
      end
    end
    wait_idle();
    checks++;
    if (bus.o_full !== 1'b1 || bus.o_free_cnt !== 4'd0) begin
      errors++;
      $display("FAIL fill_full: got full %0b cnt %0d expected 1 0", bus.o_full, bus.o_free_cnt);
    end
    run_alloc(g, nk, pg, lat);
    checks++;
    if (!nk || g || lat !== 1) begin
      errors++;
      $display("FAIL nack: got nack %0b gnt %0b lat %0d expected 1 0 1", nk, g, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.o_free_cnt !== 4'd0 || bus.o_alloc_nack !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL nack_after: got cnt %0d nack %0b busy %0b expected 0 0 0",
               bus.o_free_cnt, bus.o_alloc_nack, bus.o_busy);
    end
  endtask

  task automatic test_free_full();
    bit a, e, g, nk; logic [2:0] pg; int lat;
    run_free(3'd5, a, e, lat);
    checks++;
    if (!a || e || lat !== 1) begin
      errors++;
      $display("FAIL free5_ack: got ack %0b err %0b lat %0d expected 1 0 1", a, e, lat);
    end
    wait_idle();
    checks++;
    if (bus.o_full !== 1'b0 || bus.o_free_cnt !== 4'd1) begin
      errors++;
      $display("FAIL free5_after: got full %0b cnt %0d expected 0 1", bus.o_full, bus.o_free_cnt);
    end
    run_alloc(g, nk, pg, lat);
    checks++;
    if (!g || pg !== 3'd5 || lat !== 4) begin
      errors++;
      $display("FAIL realloc5: got gnt %0b page %0d lat %0d expected 1 5 4", g, pg, lat);
    end
    wait_idle();
  endtask

  task automatic test_free_err();
    bit a, e, g, nk; logic [2:0] pg; int lat;
    do_reset();
    run_free(3'd3, a, e, lat);
    checks++;
    if (!e || a || lat !== 1) begin
      errors++;
      $display("FAIL free_err: got err %0b ack %0b lat %0d expected 1 0 1", e, a, lat);
    end
    wait_idle();
    checks++;
    if (bus.o_free_cnt !== 4'd8 || bus.o_full !== 1'b0) begin
      errors++;
      $display("FAIL free_err_state: got cnt %0d full %0b expected 8 0", bus.o_free_cnt, bus.o_full);
    end
    run_alloc(g, nk, pg, lat);
    checks++;
    if (!g || pg !== 3'd0) begin
      errors++;
      $display("FAIL free_err_tree: got gnt %0b page %0d expected 1 0", g, pg);
    end
    wait_idle();
  endtask

  task automatic test_priority();
    bit g, nk; logic [2:0] pg; int lat;
    int ack_cyc, gnt_cyc, n;
    logic [2:0] gpage;
    do_reset();
    run_alloc(g, nk, pg, lat); wait_idle();
    run_alloc(g, nk, pg, lat); wait_idle();
    ack_cyc = 0; gnt_cyc = 0; gpage = 3'd7; n = 0;
    bus.i_alloc_req = 1'b1;
    bus.i_free_vld  = 1'b1;
    bus.i_free_page = 3'd0;
    while ((gnt_cyc == 0 || ack_cyc == 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.o_free_ack) begin
        ack_cyc = n;
        bus.i_free_vld = 1'b0;
      end
      if (bus.o_alloc_gnt) begin
        gnt_cyc = n;
        gpage   = bus.o_alloc_page;
        bus.i_alloc_req = 1'b0;
      end
    end
    bus.i_alloc_req = 1'b0;
    bus.i_free_vld  = 1'b0;
    checks++;
    if (ack_cyc !== 1 || gnt_cyc !== 9) begin
      errors++;
      $display("FAIL prio_order: got ack@%0d gnt@%0d expected ack@1 gnt@9", ack_cyc, gnt_cyc);
    end
    checks++;
    if (gpage !== 3'd0) begin
      errors++;
      $display("FAIL prio_page: got %0d expected 0", gpage);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_walk();
    int seen;
    bit g, nk; logic [2:0] pg; int lat;
    do_reset();
    bus.i_alloc_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    bus.i_alloc_req = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | int'(bus.o_alloc_gnt);
    end
    rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen = seen | int'(bus.o_alloc_gnt);
    end
    checks++;
    if (seen !== 0 || bus.o_free_cnt !== 4'd8 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_walk: got gnt_seen %0d cnt %0d busy %0b expected 0 8 0",
               seen, bus.o_free_cnt, bus.o_busy);
    end
    run_alloc(g, nk, pg, lat);
    checks++;
    if (!g || pg !== 3'd0) begin
      errors++;
      $display("FAIL reset_walk_next: got gnt %0b page %0d expected 1 0", g, pg);
    end
    wait_idle();
  endtask

  task automatic test_rotate();
    bit g, nk; logic [2:0] pg; int lat;
    logic [2:0] exp_pg [4];
    exp_pg[0] = 3'd0; exp_pg[1] = 3'd7; exp_pg[2] = 3'd1; exp_pg[3] = 3'd6;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_alloc(g, nk, pg, lat);
      checks++;
      if (!g || pg !== exp_pg[i]) begin
        errors++;
        $display("FAIL rotate_page%0d: got gnt %0b page %0d expected 1 %0d", i, g, pg, exp_pg[i]);
      end
      wait_idle();
    end
    checks++;
    if (bus.o_free_cnt !== 4'd4) begin
      errors++;
      $display("FAIL rotate_cnt: got %0d expected 4", bus.o_free_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.i_alloc_req = 1'b0;
    bus.i_free_vld  = 1'b0;
    bus.i_free_page = 3'd0;
    test_reset();
`ifdef QPL_ALLOC_ROTATE_EN
    test_rotate();
    test_reset_mid_walk();
`else
    test_single_alloc();
    test_fill_and_nack();
    test_free_full();
    test_free_err();
    test_priority();
    test_reset_mid_walk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_alloc_ctrl.md
Name: page_alloc_ctrl

Overview:
- Sequences the page-status tree. Serves single-page allocate and free requests against a heap-indexed binary tree of "subtree full" bits.
- Each allocation walks the tree root-to-leaf, one level per cycle, using the same steering rule as the decode nodes.
- Ancestor full bits are then repaired leaf-to-root.
- Sits between the page-request front end and the status-bit store. It is the only writer of that store.

Parameters:
- PAGES, 16, number of pages. Power of two, ≥4.
- DEPTH, $clog2(PAGES), tree depth. Derived, not overridable.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_alloc_req  in  1  allocate request; held high until o_alloc_gnt or o_alloc_nack
- o_alloc_gnt  out  1  one-cycle pulse: page granted
- o_alloc_nack  out  1  one-cycle pulse: no free page
- o_alloc_page  out  DEPTH  granted page index; valid with o_alloc_gnt
- i_free_vld  in  1  free request; held high until o_free_ack or o_err
- i_free_page  in  DEPTH  page to free; stable while i_free_vld
- o_free_ack  out  1  one-cycle pulse: page freed
- o_err  out  1  one-cycle pulse: freed page was already free
- o_busy  out  1  FSM not in IDLE
- o_full  out  1  root full bit
- o_free_cnt  out  DEPTH+1  number of free pages

Behaviour:
- Reset is asynchronous, active-low.
  - All full[1..2*PAGES-1] bits = 0.
  - State = IDLE, o_free_cnt = PAGES.
  - All pulses = 0, o_alloc_page = 0.
- Reset mid-operation aborts the operation silently: no grant, ack or error is issued.
- FSM states: IDLE, WALK, COMMIT, FCHK, UPDATE.
- IDLE:
  - Free has priority if i_free_vld and i_alloc_req are both high. The alloc is served after return to IDLE.
  - i_free_vld → FCHK.
  - Else i_alloc_req with full[1]=1 → o_alloc_nack on the next cycle, back to IDLE, no state change.
  - Else i_alloc_req → WALK with idx=1, lvl=0.
- WALK, one level per cycle:
  - scb = full[2*idx]; inv = policy bit.
  - go_right = scb ^ inv, except when the preferred child is full: then take the other child (never enter a full subtree).
  - idx ← 2*idx + go_right.
  - After DEPTH cycles → COMMIT.
- COMMIT:
  - Set full[idx] = 1.
  - o_alloc_gnt = 1, o_alloc_page = idx − PAGES.
  - o_free_cnt decrements.
  - → UPDATE.
- FCHK, with leaf = PAGES + i_free_page:
  - If full[leaf] = 0: o_err pulse, → IDLE.
  - Else: clear full[leaf], o_free_ack pulse, o_free_cnt increments, → UPDATE.
- UPDATE, DEPTH cycles:
  - idx ← idx>>1; full[idx] ← full[2*idx] & full[2*idx+1].
  - After the root is updated → IDLE.
- Latency, with the request accepted in cycle T:
  - Grant at T+DEPTH+1.
  - Ack/err at T+1.
  - Nack at T+1.
  - o_busy stays high through UPDATE. A new request is accepted no earlier than T+2*DEPTH+2 (alloc) or T+DEPTH+2 (free).
- Invariants:
  - o_free_cnt never wraps: 0 ≤ cnt ≤ PAGES.
  - o_full == (o_free_cnt == 0) whenever in IDLE.
- Requests arriving while o_busy are ignored until IDLE. Requesters keep them asserted.

Optional Feature:
- Macro: QPL_ALLOC_ROTATE_EN.
- Defined: the policy bit inv toggles after every successful COMMIT (reset value 0). Allocations alternate between lowest-free-first and highest-free-first.
- Undefined: inv is tied to 0. Allocation is always lowest free index first.

Decomposition:
- Shared package qpl_pkg holds:
  - the FSM state enum typedef
  - heap-index helpers: leaf base = PAGES, parent = idx>>1, children
- One sub-module, pa_walk_step: combinational steering for one level.
  - Inputs: left-full, right-full, inv.
  - Outputs: go_right, stuck (both children full, which is an assertion).
  - Instantiated once inside the controller.

Test Plan (PAGES=8, DEPTH=3, macro undefined unless noted):
- Reset, then one alloc_req at T → o_alloc_gnt at T+4 with page 0; o_free_cnt=7; o_busy low at T+8.
- Eight back-to-back allocs → pages 0..7 in order; o_full=1; ninth req → o_alloc_nack at T+1, o_free_cnt stays 0.
- Full tree, free page 5 → o_free_ack at T+1; o_full=0 after UPDATE; next alloc returns page 5.
- Free page 3 when never allocated → o_err at T+1; o_free_cnt and all full bits unchanged.
- After two allocs, assert alloc_req and free_vld (page 0) in the same cycle → ack first; the subsequent alloc returns page 0.
- QPL_ALLOC_ROTATE_EN defined, four allocs from reset → pages 0, 7, 1, 6; reset asserted during WALK → no grant, o_free_cnt=8.
